mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage with integrated MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes its M-suffixed outputs. It performs loads and stores over a single-outstanding req/ack data bus with arbitrary wait states, freezes upstream stages with `stallM` while a transfer is pending, and registers the writeback bundle (W-suffixed) for the register file.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of BUSY cycles before a bus transfer is aborted (used only with `MEM_TIMEOUT_EN`); legal range 2..65535.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `Regfile_weM`  in  1  register-file write enable from EX/MEM.
- `DataMem_weM`  in  1  store request from EX/MEM.
- `memToRegM`  in  1  load request; the result is taken from the bus.
- `writeRegAddrM`  in  5  destination register.
- `aluOutM`  in  32  ALU result; also the memory byte address.
- `writeDataM`  in  32  store data.
- `dbus_req`  out  1  bus request.
- `dbus_we`  out  1  1 = write, 0 = read.
- `dbus_addr`  out  32  word-aligned address.
- `dbus_wdata`  out  32  store data.
- `dbus_rdata`  in  32  read data; valid when `dbus_ack` is high.
- `dbus_ack`  in  1  transfer complete, one-cycle pulse.
- `stallM`  out  1  upstream stages hold while this is high.
- `Regfile_weW`  out  1  registered write enable.
- `writeRegAddrW`  out  5  registered destination.
- `resultW`  out  32  registered writeback data.
- `memErrW`  out  1  registered bus-timeout flag.

## Operation
- Access condition: `acc = DataMem_weM | memToRegM`. If both inputs are high, the store takes priority; `dbus_we` is 1 and the result is the ALU value.
- FSM states: IDLE and BUSY.
- IDLE with `acc=0`:
  - `dbus_req=0`, `stallM=0`.
  - MEM/WB loads `Regfile_weM`, `writeRegAddrM` and `aluOutM`.
- IDLE with `acc=1`:
  - `dbus_req=1`, combinational from the inputs.
  - `dbus_addr = {aluOutM[31:2],2'b00}`, `dbus_we = DataMem_weM`, `dbus_wdata = writeDataM`.
  - If `dbus_ack=1` in the same cycle, the transfer completes (see below) and the state stays IDLE.
  - Otherwise `stallM=1`, the state goes to BUSY and the wait counter is cleared.
- BUSY:
  - `dbus_req` is held high with address, we and wdata unchanged. Upstream is frozen, so the M inputs stay stable.
  - `stallM = ~dbus_ack`.
- Completion (ack cycle):
  - `stallM=0`.
  - MEM/WB loads `Regfile_weM`, `writeRegAddrM`, and `resultW = memToRegM & ~DataMem_weM ? dbus_rdata : aluOutM`.
  - The state goes to IDLE.
- Stall cycles: MEM/WB loads a bubble: `Regfile_weW=0`, `writeRegAddrW=0`, `resultW=0`, `memErrW=0`. The instruction therefore writes back exactly once.
- Ignored inputs:
  - `dbus_ack` in IDLE with `acc=0` is ignored.
  - `dbus_rdata` on stores is ignored.
- Address bits [1:0] are dropped; there is no misalignment detection.
- Destination register 0 is passed through unchanged; the register file discards the write.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE, wait counter 0.
  - `Regfile_weW=0`, `writeRegAddrW=0`, `resultW=0`, `memErrW=0`.
  - `dbus_req=0`, `stallM=0` (these are combinational and follow from IDLE with inputs cleared upstream).
- Reset mid-transfer: `dbus_req` drops immediately and the pending transfer is abandoned. The bus slave must tolerate a dropped request.
- Latency:
  - Non-memory instruction: MEM inputs appear on the W outputs 1 cycle later.
  - Memory instruction with N wait cycles (ack in the N-th cycle after the request, N=0 meaning same-cycle ack): `stallM` is high for N cycles, and the W outputs are valid 1 cycle after the ack.
- Combinational paths: `dbus_ack → stallM` and `M inputs → dbus_*`.
- Back-to-back accesses: the next instruction's request is driven in the cycle after completion. There is no idle gap.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - The wait counter, of width `$clog2(TIMEOUT_CYCLES+1)`, increments on every BUSY cycle without ack.
  - In a BUSY cycle where the counter equals `TIMEOUT_CYCLES-1` and there is no ack, the transfer aborts: `dbus_req` is 0 from the next cycle, `stallM=0` in that cycle, MEM/WB loads `Regfile_weW=0`, `resultW=0`, `memErrW=1`, and the state goes to IDLE.
  - `memErrW` is high for exactly one cycle.
  - An ack in the timeout cycle wins and completes normally.
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely and `memErrW` is constant 0.

## Test plan
- ALU op: `Regfile_weM=1`, `writeRegAddrM=5`, `aluOutM=0x1234`, no access. Required next cycle: `Regfile_weW=1`, `writeRegAddrW=5`, `resultW=0x1234`, and `stallM` never rises.
- Zero-wait load: `memToRegM=1`, `aluOutM=0x103`, ack in the same cycle with `rdata=0xDEADBEEF`. Required: `dbus_addr=0x100`, `stallM=0`, and `resultW=0xDEADBEEF` next cycle.
- 3-wait store: `DataMem_weM=1`, `writeDataM=0xA5A5A5A5`, ack on the 4th request cycle. Required: `stallM` high for 3 cycles, `dbus_we=1` with stable wdata, `Regfile_weW=0` throughout, and `dbus_req` low after the ack.
- Back-to-back loads (wait 2, then wait 0). Required: each load writes back exactly once, in order, with bubbles only during the stall cycles.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, load with no ack. Required: `dbus_req` high for 5 cycles (1 IDLE request cycle plus 4 BUSY), `stallM` high for 4 cycles, then `memErrW=1` for 1 cycle with `Regfile_weW=0`. Repeat with ack in the 4th BUSY cycle: normal completion and `memErrW=0`.
- Assert `rst` during BUSY. Required: `dbus_req`, `stallM` and all W outputs go to 0 asynchronously, and after release the next access starts from IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage + MEM/WB register; single-outstanding req/ack bus, bus timeout under `MEM_TIMEOUT_EN`.
// Latency 1 cycle to W outputs after completion; stallM holds upstream while a transfer waits for ack.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Regfile_weM,
    input  logic        DataMem_weM,
    input  logic        memToRegM,
    input  logic [4:0]  writeRegAddrM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stallM,
    output logic        Regfile_weW,
    output logic [4:0]  writeRegAddrW,
    output logic [31:0] resultW,
    output logic        memErrW
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES out of range 2..65535");
    end

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       acc;
    logic       busy;
    logic       active;
    logic       pend;
    logic       abort;
    logic       load_sel;

    assign acc      = DataMem_weM | memToRegM;
    assign busy     = (state == BUSY);
    assign active   = busy | acc;
    assign load_sel = memToRegM & ~DataMem_weM;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // Last permitted BUSY cycle without ack gives up the transfer.
    assign abort = busy & ~dbus_ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!busy) begin
            wait_cnt <= '0;
        end else if (!dbus_ack) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign abort = 1'b0;
`endif

    assign pend = active & ~dbus_ack & ~abort;

    // Gated by rst so the bus request and stall drop the instant reset hits.
    assign dbus_req   = active & ~rst;
    assign stallM     = pend & ~rst;
    assign dbus_we    = DataMem_weM;
    assign dbus_addr  = {aluOutM[31:2], 2'b00};
    assign dbus_wdata = writeDataM;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc && !dbus_ack) state_nxt = BUSY;
            BUSY:    if (dbus_ack || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stall cycles write a bubble so each instruction retires exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Regfile_weW   <= 1'b0;
            writeRegAddrW <= 5'd0;
            resultW       <= 32'd0;
            memErrW       <= 1'b0;
        end else if (pend) begin
            Regfile_weW   <= 1'b0;
            writeRegAddrW <= 5'd0;
            resultW       <= 32'd0;
            memErrW       <= 1'b0;
        end else if (abort) begin
            Regfile_weW   <= 1'b0;
            writeRegAddrW <= 5'd0;
            resultW       <= 32'd0;
            memErrW       <= 1'b1;
        end else begin
            Regfile_weW   <= Regfile_weM;
            writeRegAddrW <= writeRegAddrM;
            resultW       <= load_sel ? dbus_rdata : aluOutM;
            memErrW       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks queued at completion, compared on the W outputs.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        Regfile_weM, DataMem_weM, memToRegM;
    logic [4:0]  writeRegAddrM;
    logic [31:0] aluOutM, writeDataM;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic        dbus_ack;
    logic        stallM, Regfile_weW, memErrW;
    logic [4:0]  writeRegAddrW;
    logic [31:0] resultW;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        err;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .Regfile_weM(Regfile_weM), .DataMem_weM(DataMem_weM), .memToRegM(memToRegM),
        .writeRegAddrM(writeRegAddrM), .aluOutM(aluOutM), .writeDataM(writeDataM),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .stallM(stallM),
        .Regfile_weW(Regfile_weW), .writeRegAddrW(writeRegAddrW), .resultW(resultW), .memErrW(memErrW)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        Regfile_weM = 0; DataMem_weM = 0; memToRegM = 0; writeRegAddrM = 0;
        aluOutM = 0; writeDataM = 0; dbus_rdata = 0; dbus_ack = 0;
    endtask

    task automatic test_reset();
        wb_t g;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== '0) begin failures++; $display("FAIL reset_w got=%h exp=0", g); end
        checks++; if ({dbus_req, stallM} !== 2'b00) begin failures++; $display("FAIL reset_req_stall got=%b exp=00", {dbus_req, stallM}); end
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        wb_t e, g;
        Regfile_weM = 1; writeRegAddrM = 5; aluOutM = 32'h1234;
        #1;
        checks++; if ({dbus_req, stallM} !== 2'b00) begin failures++; $display("FAIL alu_req_stall got=%b exp=00", {dbus_req, stallM}); end
        exp_q.push_back(wb_t'{1'b1, 5'd5, 32'h1234, 1'b0});
        @(negedge clk);
        checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stallM); end
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL alu_wb got=%h exp=%h", g, e); end
        clear_inputs();
    endtask

    task automatic test_load_zero_wait();
        wb_t e, g;
        Regfile_weM = 1; memToRegM = 1; writeRegAddrM = 7; aluOutM = 32'h103;
        dbus_ack = 1; dbus_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (dbus_req !== 1'b1) begin failures++; $display("FAIL zw_req got=%b exp=1", dbus_req); end
        checks++; if (dbus_addr !== 32'h100) begin failures++; $display("FAIL zw_addr got=%h exp=00000100", dbus_addr); end
        checks++; if ({dbus_we, stallM} !== 2'b00) begin failures++; $display("FAIL zw_we_stall got=%b exp=00", {dbus_we, stallM}); end
        exp_q.push_back(wb_t'{1'b1, 5'd7, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL zw_wb got=%h exp=%h", g, e); end
        clear_inputs();
    endtask

    task automatic test_store_wait();
        wb_t e, g;
        int  stalls = 0;
        DataMem_weM = 1; writeDataM = 32'hA5A5A5A5; aluOutM = 32'h2000; dbus_rdata = 32'hFFFF0000;
        for (int c = 0; c < 4; c++) begin
            dbus_ack = (c == 3);
            #1;
            if (stallM === 1'b1) stalls++;
            checks++;
            if ({dbus_req, dbus_we, dbus_addr, dbus_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hA5A5A5A5}) begin
                failures++; $display("FAIL st_bus c=%0d got=%b/%b/%h/%h exp=1/1/00002000/a5a5a5a5", c, dbus_req, dbus_we, dbus_addr, dbus_wdata);
            end
            checks++; if (stallM !== (c != 3)) begin failures++; $display("FAIL st_stall c=%0d got=%b exp=%b", c, stallM, c != 3); end
            if (c == 3) exp_q.push_back(wb_t'{1'b0, 5'd0, 32'h2000, 1'b0});
            @(negedge clk);
            if (c < 3) begin
                g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
                checks++; if (g !== '0) begin failures++; $display("FAIL st_bubble c=%0d got=%h exp=0", c, g); end
            end
        end
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL st_wb got=%h exp=%h", g, e); end
        checks++; if (stalls != 3) begin failures++; $display("FAIL st_stall_count got=%0d exp=3", stalls); end
        clear_inputs();
        #1;
        checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL st_req_after got=%b exp=0", dbus_req); end
    endtask

    task automatic test_back_to_back();
        wb_t e, g;
        Regfile_weM = 1; memToRegM = 1; writeRegAddrM = 3; aluOutM = 32'h40;
        for (int c = 0; c < 3; c++) begin
            dbus_ack = (c == 2);
            dbus_rdata = (c == 2) ? 32'h11111111 : 32'h0;
            #1;
            checks++; if ({dbus_req, stallM} !== {1'b1, c != 2}) begin failures++; $display("FAIL b2b_a c=%0d got=%b exp=%b", c, {dbus_req, stallM}, {1'b1, c != 2}); end
            if (c == 2) exp_q.push_back(wb_t'{1'b1, 5'd3, 32'h11111111, 1'b0});
            @(negedge clk);
            if (c < 2) begin
                g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
                checks++; if (g !== '0) begin failures++; $display("FAIL b2b_bubble c=%0d got=%h exp=0", c, g); end
            end
        end
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL b2b_wb_a got=%h exp=%h", g, e); end
        writeRegAddrM = 4; aluOutM = 32'h44; dbus_ack = 1; dbus_rdata = 32'h22222222;
        #1;
        checks++; if ({dbus_req, stallM, dbus_addr} !== {2'b10, 32'h44}) begin failures++; $display("FAIL b2b_b_req got=%b/%b/%h exp=1/0/00000044", dbus_req, stallM, dbus_addr); end
        exp_q.push_back(wb_t'{1'b1, 5'd4, 32'h22222222, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL b2b_wb_b got=%h exp=%h", g, e); end
        clear_inputs();
        @(negedge clk);
        checks++; if (Regfile_weW !== 1'b0) begin failures++; $display("FAIL b2b_extra_wb got=%b exp=0", Regfile_weW); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        wb_t e, g;
        int  reqs = 0;
        int  stalls = 0;
        Regfile_weM = 1; memToRegM = 1; writeRegAddrM = 9; aluOutM = 32'h80; dbus_rdata = 32'h99999999;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (dbus_req === 1'b1) reqs++;
            if (stallM === 1'b1) stalls++;
            @(negedge clk);
            if (c < 4) begin
                g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
                checks++; if (g !== '0) begin failures++; $display("FAIL to_bubble c=%0d got=%h exp=0", c, g); end
            end
        end
        checks++; if ({memErrW, Regfile_weW, resultW} !== {2'b10, 32'h0}) begin failures++; $display("FAIL to_err got=%b/%b/%h exp=1/0/0", memErrW, Regfile_weW, resultW); end
        checks++; if (reqs != 5) begin failures++; $display("FAIL to_req_count got=%0d exp=5", reqs); end
        checks++; if (stalls != 4) begin failures++; $display("FAIL to_stall_count got=%0d exp=4", stalls); end
        clear_inputs();
        #1;
        checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL to_req_after got=%b exp=0", dbus_req); end
        @(negedge clk);
        checks++; if (memErrW !== 1'b0) begin failures++; $display("FAIL to_err_pulse got=%b exp=0", memErrW); end
        Regfile_weM = 1; memToRegM = 1; writeRegAddrM = 9; aluOutM = 32'h80;
        for (int c = 0; c < 5; c++) begin
            dbus_ack = (c == 4);
            dbus_rdata = 32'h55AA55AA;
            #1;
            checks++; if (stallM !== (c != 4)) begin failures++; $display("FAIL to_ack_stall c=%0d got=%b exp=%b", c, stallM, c != 4); end
            if (c == 4) exp_q.push_back(wb_t'{1'b1, 5'd9, 32'h55AA55AA, 1'b0});
            @(negedge clk);
        end
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL to_ack_wb got=%h exp=%h", g, e); end
        clear_inputs();
    endtask
`endif

    task automatic test_reset_busy();
        wb_t e, g;
        Regfile_weM = 1; writeRegAddrM = 12; aluOutM = 32'hCAFE;
        @(posedge clk);
        #2;
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== wb_t'{1'b1, 5'd12, 32'hCAFE, 1'b0}) begin failures++; $display("FAIL rb_pre got=%h", g); end
        rst = 1'b1;
        clear_inputs();
        #1;
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== '0) begin failures++; $display("FAIL rb_async_w got=%h exp=0", g); end
        @(negedge clk);
        rst = 1'b0;
        Regfile_weM = 1; memToRegM = 1; writeRegAddrM = 13; aluOutM = 32'h300;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++; if ({dbus_req, stallM} !== 2'b00) begin failures++; $display("FAIL rb_busy got=%b exp=00", {dbus_req, stallM}); end
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== '0) begin failures++; $display("FAIL rb_busy_w got=%h exp=0", g); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL rb_idle_req got=%b exp=0", dbus_req); end
        @(negedge clk);
        Regfile_weM = 1; memToRegM = 1; writeRegAddrM = 14; aluOutM = 32'h304;
        dbus_ack = 1; dbus_rdata = 32'h0BADF00D;
        #1;
        checks++; if ({dbus_req, stallM} !== 2'b10) begin failures++; $display("FAIL rb_next_req got=%b exp=10", {dbus_req, stallM}); end
        exp_q.push_back(wb_t'{1'b1, 5'd14, 32'h0BADF00D, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        g = {Regfile_weW, writeRegAddrW, resultW, memErrW};
        checks++; if (g !== e) begin failures++; $display("FAIL rb_next_wb got=%h exp=%h", g, e); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_zero_wait();
        test_store_wait();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_busy();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
